// File: rtl/ama_riscv_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues in-order imem requests and buffers {pc, inst} for the decoder.
// Define FETCH_SKID_EN for a 2-deep buffer with two requests in flight; otherwise the buffer is 1 deep.
module ama_riscv_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    output logic        imem_rsp_ready,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        dec_ready,
    output logic [31:0] inst_dec,
    output logic [31:0] pc_dec
);

`ifdef FETCH_SKID_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] pc_f;
    logic [1:0]  outstanding;
    logic [1:0]  drop_cnt;
    logic        rsp_ready_q;
    logic [31:0] aq        [DEPTH];
    logic        fifo_v    [DEPTH];
    logic [31:0] fifo_pc   [DEPTH];
    logic [31:0] fifo_inst [DEPTH];

    logic [31:0] pc_f_n;
    logic [1:0]  outstanding_n;
    logic [1:0]  drop_cnt_n;
    logic [31:0] aq_n      [DEPTH];
    logic        fv_n      [DEPTH];
    logic [31:0] fpc_n     [DEPTH];
    logic [31:0] finst_n   [DEPTH];

    logic        req_fire;
    logic        rsp_fire;
    logic        deq_fire;
    logic        push;
    logic        placed;
    logic [1:0]  count;
    logic [1:0]  aq_idx;
    logic [2:0]  credit_used;

    assign inst_valid     = fifo_v[0];
    assign inst_dec       = fifo_inst[0];
    assign pc_dec         = fifo_pc[0];
    assign imem_req_addr  = pc_f;
    assign imem_rsp_ready = rsp_ready_q;

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            count = count + {1'b0, fifo_v[i]};
        end
    end

    // Credits cover both in-flight requests and buffered instructions, so neither queue can overflow.
    assign deq_fire       = inst_valid && dec_ready;
    assign credit_used    = {1'b0, outstanding} + {1'b0, count} - {2'b00, deq_fire};
    assign imem_req_valid = rst && !redirect && (credit_used < 3'(DEPTH));
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_fire       = imem_rsp_valid && imem_rsp_ready;
    assign push           = rsp_fire && !redirect && (drop_cnt == '0);

    always_comb begin
        pc_f_n = pc_f;
        if (redirect) begin
            pc_f_n = {redirect_pc[31:2], 2'b00};
        end else if (req_fire) begin
            pc_f_n = pc_f + 32'd4;
        end

        outstanding_n = outstanding + {1'b0, req_fire} - {1'b0, rsp_fire};

        drop_cnt_n = drop_cnt;
        if (redirect) begin
            drop_cnt_n = outstanding - {1'b0, rsp_fire};
        end else if (rsp_fire && (drop_cnt != '0)) begin
            drop_cnt_n = drop_cnt - 2'd1;
        end
    end

    // Address queue is never flushed: stale PCs drain in step with the stale responses.
    always_comb begin
        aq_n   = aq;
        aq_idx = outstanding - {1'b0, rsp_fire};
        if (rsp_fire) begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                aq_n[i] = aq[i+1];
            end
        end
        if (req_fire) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (aq_idx == 2'(i)) begin
                    aq_n[i] = pc_f;
                end
            end
        end
    end

    // Slot 0 is the decoder-facing head; empty slots hold NOP/0 so the outputs come straight from flops.
    always_comb begin
        fv_n    = fifo_v;
        fpc_n   = fifo_pc;
        finst_n = fifo_inst;
        placed  = 1'b0;
        if (deq_fire) begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                fv_n[i]    = fifo_v[i+1];
                fpc_n[i]   = fifo_pc[i+1];
                finst_n[i] = fifo_inst[i+1];
            end
            fv_n[DEPTH-1]    = 1'b0;
            fpc_n[DEPTH-1]   = '0;
            finst_n[DEPTH-1] = NOP;
        end
        if (push) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (!placed && !fv_n[i]) begin
                    fv_n[i]    = 1'b1;
                    fpc_n[i]   = aq[0];
                    finst_n[i] = imem_rsp_data;
                    placed     = 1'b1;
                end
            end
        end
        if (redirect) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fv_n[i]    = 1'b0;
                fpc_n[i]   = '0;
                finst_n[i] = NOP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_f        <= RESET_VECTOR;
            outstanding <= '0;
            drop_cnt    <= '0;
            rsp_ready_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                aq[i]        <= '0;
                fifo_v[i]    <= 1'b0;
                fifo_pc[i]   <= '0;
                fifo_inst[i] <= NOP;
            end
        end else begin
            pc_f        <= pc_f_n;
            outstanding <= outstanding_n;
            drop_cnt    <= drop_cnt_n;
            rsp_ready_q <= 1'b1;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                aq[i]        <= aq_n[i];
                fifo_v[i]    <= fv_n[i];
                fifo_pc[i]   <= fpc_n[i];
                fifo_inst[i] <= finst_n[i];
            end
        end
    end

endmodule

// File: tb/tb_ama_riscv_fetch.sv
// Scoreboard bench for ama_riscv_fetch: directed phases drive a latency-configurable memory model,
// a monitor pops expected {pc, inst} pairs on every decoder handshake.
module tb_ama_riscv_fetch;
`ifdef FETCH_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic        imem_rsp_ready;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] inst_dec;
    logic [31:0] pc_dec;

    ama_riscv_fetch #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_ready (imem_rsp_ready),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .dec_ready      (dec_ready),
        .inst_dec       (inst_dec),
        .pc_dec         (pc_dec)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory model: responses in request order, mem_lat cycles after acceptance.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t       mq[$];
    int          cyc = 0;
    int          mem_lat = 1;
    int          bench_out = 0;
    int          max_out = 0;
    logic [31:0] last_addr = '0;

    always @(negedge clk) begin
        cyc++;
        #1;
        if (!rst) begin
            mq.delete();
            bench_out = 0;
            imem_rsp_valid = 1'b0;
            imem_rsp_data = '0;
        end else begin
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data = mem_word(mq[0].addr);
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data = '0;
            end
            #1;
            if (imem_rsp_valid && imem_rsp_ready) begin
                void'(mq.pop_front());
                bench_out--;
            end
            if (imem_req_valid && imem_req_ready) begin
                mq.push_back('{imem_req_addr, cyc + mem_lat});
                last_addr = imem_req_addr;
                bench_out++;
                if (bench_out > max_out) max_out = bench_out;
            end
        end
    end

    logic [31:0] exp_q[$];
    int          n_deq = 0;

    task automatic fill_exp(input logic [31:0] start);
        logic [31:0] p;
        exp_q.delete();
        p = start;
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(p);
            p = p + 32'd4;
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (rst && inst_valid && dec_ready) begin
            n_deq++;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_pc", pc_dec, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("sb_pc", pc_dec, e);
                chk("sb_inst", inst_dec, mem_word(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          d;
        logic        found;
        logic        got;
        logic [31:0] a;
        logic [31:0] resume;

        repeat (2) @(negedge clk);
        #2;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_rsp_ready", imem_rsp_ready, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst_dec", inst_dec, NOP);
        chk("rst_pc_dec", pc_dec, 0);

        // Boot
        @(negedge clk);
        fill_exp(32'h0);
        rst = 1'b1;
        dec_ready = 1'b1;
        #2;
        chk("boot_c0_req_valid", imem_req_valid, 1);
        chk("boot_c0_req_addr", imem_req_addr, 32'h0);
        @(negedge clk); #2;
        chk("boot_c1_req_valid", imem_req_valid, (DEPTH == 2) ? 1 : 0);
        chk("boot_c1_req_addr", imem_req_addr, 32'h4);
        @(negedge clk); #2;
        chk("boot_c2_inst_valid", inst_valid, 1);
        chk("boot_c2_pc_dec", pc_dec, 32'h0);
        chk("boot_c2_req_valid", imem_req_valid, 1);
        chk("boot_c2_req_addr", imem_req_addr, (DEPTH == 2) ? 32'h8 : 32'h4);
        #2;
        d = n_deq;
        repeat (8) @(negedge clk);
        #4;
        chk("boot_throughput", n_deq - d, (DEPTH == 2) ? 8 : 4);

        // Decoder stall for 5 cycles
        @(negedge clk);
        dec_ready = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("stall_req_valid", imem_req_valid, 0);
        chk("stall_inst_valid", inst_valid, 1);
        repeat (2) @(negedge clk);
        dec_ready = 1'b1;
        repeat (6) @(negedge clk);

        // Memory backpressure for 3 cycles
        imem_req_ready = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        resume = last_addr + 32'd4;
        chk("bp_req_valid", imem_req_valid, 1);
        chk("bp_req_addr", imem_req_addr, resume);
        @(negedge clk);
        imem_req_ready = 1'b1;
        #2;
        chk("bp_resume_valid", imem_req_valid, 1);
        chk("bp_resume_addr", imem_req_addr, resume);
        repeat (6) @(negedge clk);

        // Redirect with the credit window full of in-flight requests
        mem_lat = 2;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bench_out == DEPTH) found = 1'b1;
        end
        chk("rd_credit_full", found, 1);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        #2;
        chk("rd_req_suppressed", imem_req_valid, 0);
        #1;
        fill_exp(32'h0000_0100);
        @(negedge clk);
        redirect = 1'b0;
        #2;
        chk("rd_inst_valid_low", inst_valid, 0);
        got = 1'b0;
        a = '0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (imem_req_valid && imem_req_ready) begin
                got = 1'b1;
                a = imem_req_addr;
            end else begin
                @(negedge clk);
                #2;
            end
        end
        chk("rd_first_req_addr", got ? a : 32'hDEAD_BEEF, 32'h0000_0100);
        mem_lat = 1;
        repeat (8) @(negedge clk);

        // Redirect near the top of the address space: fetch PC must wrap to 0
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        #3;
        fill_exp(32'hFFFF_FFFC);
        d = n_deq;
        @(negedge clk);
        redirect = 1'b0;
        repeat (8) @(negedge clk);
        #4;
        chk("wrap_progress", (n_deq - d) >= 2, 1);

        // Asynchronous reset mid-stream with a backed-up buffer
        @(negedge clk);
        dec_ready = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_req_valid", imem_req_valid, 0);
        chk("arst_rsp_ready", imem_rsp_ready, 0);
        chk("arst_inst_valid", inst_valid, 0);
        chk("arst_inst_dec", inst_dec, NOP);
        chk("arst_pc_dec", pc_dec, 0);
        @(negedge clk);
        @(negedge clk);
        fill_exp(32'h0);
        rst = 1'b1;
        dec_ready = 1'b1;
        #2;
        chk("rerun_req_valid", imem_req_valid, 1);
        chk("rerun_req_addr", imem_req_addr, 32'h0);
        #2;
        d = n_deq;
        repeat (11) @(negedge clk);
        #4;
        chk("rerun_throughput", n_deq - d, (DEPTH == 2) ? 10 : 5);

        chk("max_outstanding", max_out <= DEPTH, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
